// File: rtl/store_merge_unit.sv
// Store merge unit: turns SB/SH/SW requests into whole-word writes on a memory
// without byte enables. Partial stores read the word, merge the new bytes into
// their big-endian lane(s) and write the word back; SW writes straight through.
// Misaligned or illegal requests are answered with a one-cycle error pulse.
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              misalign,
    output logic [3:0]        wmask
);

    // Store opcodes (MIPS encoding, same values as the shared opcode header)
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    logic [2:0]        state_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [1:0]        off_q;
    logic              half_q;
    logic [15:0]       sdata_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;

    logic              req_ok;
    logic [31:0]       merged;
    logic [3:0]        lanes;

    // Alignment/legality of the request presented on the inputs
    always_comb begin
        req_ok = 1'b0;
        if (opcode == OP_SB) begin
            req_ok = 1'b1;
        end else if (opcode == OP_SH) begin
            req_ok = ~addr[0];
        end else if (opcode == OP_SW) begin
            req_ok = (addr[1:0] == 2'b00);
        end
    end

    // Merge the registered store bytes into the word returned by the read
    always_comb begin
        merged = mem_rdata;
        lanes  = 4'b0000;
        if (half_q) begin
            if (off_q[1]) begin
                merged[15:0] = sdata_q;
                lanes        = 4'b0011;
            end else begin
                merged[31:16] = sdata_q;
                lanes         = 4'b1100;
            end
        end else begin
            unique case (off_q)
                2'd0: begin merged[31:24] = sdata_q[7:0]; lanes = 4'b1000; end
                2'd1: begin merged[23:16] = sdata_q[7:0]; lanes = 4'b0100; end
                2'd2: begin merged[15:8]  = sdata_q[7:0]; lanes = 4'b0010; end
                2'd3: begin merged[7:0]   = sdata_q[7:0]; lanes = 4'b0001; end
            endcase
        end
    end

    // Transaction sequencing and registered request/write data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            waddr_q <= '0;
            off_q   <= 2'd0;
            half_q  <= 1'b0;
            sdata_q <= 16'h0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        waddr_q <= addr[ADDR_W-1:2];
                        off_q   <= addr[1:0];
                        half_q  <= (opcode == OP_SH);
                        // only the low halfword can ever be merged
                        sdata_q <= store_data[15:0];
                        if (!req_ok) begin
                            state_q <= ERR;
                        end else if (opcode == OP_SW) begin
                            wdata_q <= store_data;
                            wmask_q <= 4'b1111;
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: state_q <= WAIT;
                WAIT: begin
                    if (mem_rvalid) begin
                        wdata_q <= merged;
                        wmask_q <= lanes;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from the registered state only
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_re    = (state_q == READ);
        mem_we    = (state_q == WRITE);
        done      = (state_q == DONE) || (state_q == ERR);
        misalign  = (state_q == ERR);
        mem_addr  = waddr_q;
        mem_wdata = wdata_q;
        wmask     = wmask_q;
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: directed scenarios plus randomized stores checked
// against a byte-lane reference model and a word-wide memory responder.
`timescale 1ns/1ps
module tb_store_merge_unit;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_LW = 6'b100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [29:0] mem_addr;
    logic        mem_re;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        done;
    logic        misalign;
    logic [3:0]  wmask;

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .addr       (addr),
        .store_data (store_data),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .done       (done),
        .misalign   (misalign),
        .wmask      (wmask)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    int vectors = 0;
    int miscompares = 0;

    // observed transaction
    int          lat, n_re, n_we;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [29:0] wa;
    bit          unstable, rdy_bad, tmo, mis;
    // expected transaction
    int          elat, ere, ewe;
    logic [31:0] ewd;
    logic [3:0]  ewm;
    logic [29:0] ewa;
    bit          emis;

    // Runs one request through the DUT, acting as the memory. Call just after a
    // negedge. rvl = cycles from mem_re to mem_rvalid, ackl = extra WRITE cycles
    // before mem_ack. After acceptance the request inputs switch to nop/na/nd.
    task automatic do_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                            input int rvl, input int ackl, input bit hold,
                            input logic [5:0] nop, input logic [31:0] na, input logic [31:0] nd);
        int t;
        int re_n;
        int we_n;
        lat = 0; n_re = 0; n_we = 0; wd = 0; wm = 0; wa = 0;
        unstable = 0; rdy_bad = 0; tmo = 0; mis = 0;
        re_n = -100;
        we_n = -100;
        req_valid = 1'b1; opcode = op; addr = a; store_data = d;
        mem_rvalid = 1'b0; mem_ack = 1'b0;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            tmo = 1;
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = hold; opcode = nop; addr = na; store_data = nd;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            mem_rvalid = 1'b0;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (req_ready) rdy_bad = 1;
            if (mem_re) begin
                n_re++;
                if (re_n < 0) re_n = n;
            end
            if (mem_we) begin
                n_we++;
                if (we_n < 0) begin
                    we_n = n; wd = mem_wdata; wm = wmask; wa = mem_addr;
                end else if ({mem_wdata, wmask, mem_addr} !== {wd, wm, wa}) begin
                    unstable = 1;
                end
            end
            if (done) begin
                lat = n;
                mis = misalign;
                break;
            end
            if (n == re_n + rvl) begin
                mem_rvalid = 1'b1;
                mem_rdata = mem[mem_addr[7:0]];
            end else if (n == re_n && rvl > 1) begin
                mem_rvalid = 1'b1;  // illegal same-cycle strobe with junk data
            end
            if (n == we_n + ackl) begin
                mem_ack = 1'b1;
                mem[wa[7:0]] = wd;
            end else if (n == re_n) begin
                mem_ack = 1'b1;     // stray ack outside WRITE
            end
        end
        if (lat == 0) tmo = 1;
        mem_rvalid = 1'b0;
        mem_ack = 1'b0;
    endtask

    // Reference: split the old word into big-endian byte lanes and overwrite
    // the lanes the store touches.
    task automatic model_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                             input int rvl, input int ackl);
        logic [7:0]  b [4];
        logic [31:0] old;
        int          off;
        bit          err;
        old = mem[a[9:2]];
        off = int'(a[1:0]);
        for (int i = 0; i < 4; i++) b[i] = old[31-8*i -: 8];
        ewm = 4'h0;
        err = 0;
        if (op == OP_SB) begin
            b[off] = d[7:0];
            ewm[3-off] = 1'b1;
        end else if (op == OP_SH && off % 2 == 0) begin
            b[off] = d[15:8];
            b[off+1] = d[7:0];
            ewm[3-off] = 1'b1;
            ewm[2-off] = 1'b1;
        end else if (op == OP_SW && off == 0) begin
            for (int i = 0; i < 4; i++) b[i] = d[31-8*i -: 8];
            ewm = 4'hf;
        end else begin
            err = 1;
        end
        if (err) begin
            ewd = 0; ewm = 0; ewa = 0; elat = 1; ere = 0; ewe = 0; emis = 1;
        end else begin
            ewd = {b[0], b[1], b[2], b[3]};
            ewa = a[31:2];
            ewe = ackl + 1;
            ere = (op == OP_SW) ? 0 : 1;
            elat = (op == OP_SW) ? 2 + ackl : 3 + rvl + ackl;
            emis = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        vectors++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++; $display("FAIL reset_strobes: got re=%b we=%b want 0 0", mem_re, mem_we);
        end
        vectors++;
        if (done !== 1'b0 || misalign !== 1'b0) begin
            miscompares++; $display("FAIL reset_done: got done=%b mis=%b want 0 0", done, misalign);
        end
        vectors++;
        if (wmask !== 4'h0 || mem_wdata !== 32'h0 || mem_addr !== 30'h0) begin
            miscompares++;
            $display("FAIL reset_data: got wmask=%b wdata=%h addr=%h want 0 0 0",
                     wmask, mem_wdata, mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sw();
        do_store(OP_SW, 32'h100, 32'hDEADBEEF, 1, 0, 0, 6'h0, 32'h0, 32'h0);
        vectors++;
        if ({wd, wm, wa} !== {32'hDEADBEEF, 4'b1111, 30'h40}) begin
            miscompares++;
            $display("FAIL sw_write: got wdata=%h wmask=%b addr=%h want deadbeef 1111 40", wd, wm, wa);
        end
        vectors++;
        if (lat !== 2 || n_re !== 0 || n_we !== 1 || mis !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_timing: got lat=%0d re=%0d we=%0d mis=%b want 2 0 1 0", lat, n_re, n_we, mis);
        end
        vectors++;
        if ({unstable, rdy_bad, tmo} !== 3'b000) begin
            miscompares++;
            $display("FAIL sw_protocol: got unstable=%b rdy_bad=%b timeout=%b want 000", unstable, rdy_bad, tmo);
        end
    endtask

    task automatic test_sb();
        mem[8'h40] = 32'h11223344;
        do_store(OP_SB, 32'h103, 32'h000000AB, 2, 0, 0, OP_SW, 32'h3, 32'hFFFFFFFF);
        vectors++;
        if ({wd, wm, wa} !== {32'h112233AB, 4'b0001, 30'h40}) begin
            miscompares++;
            $display("FAIL sb_write: got wdata=%h wmask=%b addr=%h want 112233ab 0001 40", wd, wm, wa);
        end
        vectors++;
        if (lat !== 5 || n_re !== 1 || n_we !== 1 || mis !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_timing: got lat=%0d re=%0d we=%0d mis=%b want 5 1 1 0", lat, n_re, n_we, mis);
        end
        vectors++;
        if ({unstable, rdy_bad, tmo} !== 3'b000) begin
            miscompares++;
            $display("FAIL sb_protocol: got unstable=%b rdy_bad=%b timeout=%b want 000", unstable, rdy_bad, tmo);
        end
    endtask

    task automatic test_sh();
        logic [31:0] a_tab [2];
        logic [31:0] w_tab [2];
        logic [3:0]  m_tab [2];
        int          r_tab [2];
        int          k_tab [2];
        a_tab = '{32'h200, 32'h202};
        w_tab = '{32'hCAFE3344, 32'h1122CAFE};
        m_tab = '{4'b1100, 4'b0011};
        r_tab = '{1, 3};
        k_tab = '{1, 0};
        for (int i = 0; i < 2; i++) begin
            mem[8'h80] = 32'h11223344;
            do_store(OP_SH, a_tab[i], 32'hFFFFCAFE, r_tab[i], k_tab[i], 0, 6'h0, 32'h0, 32'h0);
            vectors++;
            if ({wd, wm, wa} !== {w_tab[i], m_tab[i], 30'h80}) begin
                miscompares++;
                $display("FAIL sh_write[%0d]: got wdata=%h wmask=%b addr=%h want %h %b 80",
                         i, wd, wm, wa, w_tab[i], m_tab[i]);
            end
            vectors++;
            if (lat !== 3 + r_tab[i] + k_tab[i] || n_re !== 1 || n_we !== k_tab[i] + 1 ||
                unstable || rdy_bad || tmo) begin
                miscompares++;
                $display("FAIL sh_timing[%0d]: got lat=%0d re=%0d we=%0d unstable=%b rdy_bad=%b timeout=%b want %0d 1 %0d 0 0 0",
                         i, lat, n_re, n_we, unstable, rdy_bad, tmo,
                         3 + r_tab[i] + k_tab[i], k_tab[i] + 1);
            end
        end
    endtask

    task automatic test_misalign();
        logic [5:0]  o_tab [3];
        logic [31:0] a_tab [3];
        o_tab = '{OP_SH, OP_SW, OP_LW};
        a_tab = '{32'h201, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            do_store(o_tab[i], a_tab[i], 32'h12345678, 1, 0, 0, 6'h0, 32'h0, 32'h0);
            vectors++;
            if (lat !== 1 || mis !== 1'b1 || n_re !== 0 || n_we !== 0 || tmo || rdy_bad) begin
                miscompares++;
                $display("FAIL misalign[%0d]: got lat=%0d mis=%b re=%0d we=%0d timeout=%b rdy_bad=%b want 1 1 0 0 0 0",
                         i, lat, mis, n_re, n_we, tmo, rdy_bad);
            end
        end
    endtask

    task automatic test_back_to_back();
        mem[8'h10] = 32'hA5A5A5A5;
        mem[8'h11] = 32'h0F0F0F0F;
        // B sits on the request inputs with req_valid high during all of A
        do_store(OP_SB, 32'h41, 32'h00000077, 1, 3, 1, OP_SB, 32'h46, 32'h00000012);
        vectors++;
        if ({wd, wm, wa} !== {32'hA577A5A5, 4'b0100, 30'h10} || unstable) begin
            miscompares++;
            $display("FAIL b2b_first: got wdata=%h wmask=%b addr=%h unstable=%b want a577a5a5 0100 10 0",
                     wd, wm, wa, unstable);
        end
        vectors++;
        if (lat !== 7 || n_we !== 4 || rdy_bad || tmo) begin
            miscompares++;
            $display("FAIL b2b_first_timing: got lat=%0d we=%0d rdy_bad=%b timeout=%b want 7 4 0 0",
                     lat, n_we, rdy_bad, tmo);
        end
        do_store(OP_SB, 32'h46, 32'h00000012, 1, 0, 0, 6'h0, 32'h0, 32'h0);
        vectors++;
        if ({wd, wm, wa} !== {32'h0F0F120F, 4'b0010, 30'h11} || lat !== 4 || tmo) begin
            miscompares++;
            $display("FAIL b2b_second: got wdata=%h wmask=%b addr=%h lat=%0d timeout=%b want 0f0f120f 0010 11 4 0",
                     wd, wm, wa, lat, tmo);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        int t;
        mem[8'h20] = 32'hCCCCCCCC;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        req_valid = 1'b1; opcode = OP_SB; addr = 32'h80; store_data = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req_ready, mem_re, mem_we, done, misalign, wmask, mem_wdata, mem_addr} !==
            {1'b1, 4'b0000, 4'h0, 32'h0, 30'h0}) begin
            miscompares++;
            $display("FAIL reset_mid_state: got ready=%b re=%b we=%b done=%b mis=%b wmask=%b wdata=%h addr=%h want 1 0 0 0 0 0 0 0",
                     req_ready, mem_re, mem_we, done, misalign, wmask, mem_wdata, mem_addr);
        end
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = mem[8'h20];
        mem_ack = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_we || mem_re || done || !req_ready) bad = 1;
        end
        mem_rvalid = 1'b0;
        mem_ack = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_mid_after: got activity after reset=1 want 0");
        end
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] a, d;
        int          sel, rvl, ackl;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom_range(0, 1023);
            d = $urandom;
            if (sel < 3) op = OP_SB;
            else if (sel < 6) op = OP_SH;
            else if (sel < 9) op = OP_SW;
            else begin
                op = 6'($urandom);
                if (op == OP_SB || op == OP_SH || op == OP_SW) op = OP_LW;
            end
            if ($urandom_range(0, 3) != 0) begin
                if (op == OP_SH) a[0] = 1'b0;
                if (op == OP_SW) a[1:0] = 2'b00;
            end
            rvl = $urandom_range(1, 3);
            ackl = $urandom_range(0, 3);
            model_txn(op, a, d, rvl, ackl);
            do_store(op, a, d, rvl, ackl, 0, 6'($urandom), $urandom, $urandom);
            vectors++;
            if ({wd, wm, wa} !== {ewd, ewm, ewa}) begin
                miscompares++;
                $display("FAIL rand_write[%0d] op=%h a=%h: got wdata=%h wmask=%b addr=%h want %h %b %h",
                         i, op, a, wd, wm, wa, ewd, ewm, ewa);
            end
            vectors++;
            if (lat !== elat || n_re !== ere || n_we !== ewe || mis !== emis ||
                unstable || rdy_bad || tmo) begin
                miscompares++;
                $display("FAIL rand_timing[%0d] op=%h a=%h: got lat=%0d re=%0d we=%0d mis=%b unstable=%b rdy_bad=%b timeout=%b want %0d %0d %0d %b 0 0 0",
                         i, op, a, lat, n_re, n_we, mis, unstable, rdy_bad, tmo, elat, ere, ewe, emis);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_sw();
        test_sb();
        test_sh();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
